serial_mul_param: RTL and testbench

SERIAL_MUL_PARAM -- requirements
Module: serial_mul_param

---
 rtl/serial_mul_param.sv | 117 +++++++++++
 tb/tb_serial_mul_param.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_mul_param.sv
// serial_mul_param: sequential shift-add multiplier, one product bit per clock.
// Operands are WIDTH bits, product is 2*WIDTH bits, latency WIDTH cycles.
// Optional feature: define SERIAL_MUL_SIGNED_EN to add the sgn input, which
// selects two's-complement operands for the operation it accompanies.
module serial_mul_param #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef SERIAL_MUL_SIGNED_EN
    input  logic                 sgn,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [WIDTH-1:0]     r_mcand;
    // Upper WIDTH bits: running partial sum; lower WIDTH bits: unconsumed multiplier.
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_p;
    logic                 r_done;
    logic                 r_sgn;

    logic                 w_sgn_in;
    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH:0]       w_upper_ext;
    logic [WIDTH:0]       w_mcand_ext;
    logic [WIDTH:0]       w_addend;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_acc_next;

`ifdef SERIAL_MUL_SIGNED_EN
    assign w_sgn_in = sgn;
`else
    assign w_sgn_in = 1'b0;
`endif

    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_state == RUN) && (r_cnt == CNT_W'(WIDTH - 1));

    // One extra bit on the partial sum absorbs the carry (unsigned) or keeps
    // the sign (signed); dropping the LSB afterwards is the right shift.
    assign w_upper_ext = {r_sgn & r_acc[2*WIDTH-1], r_acc[2*WIDTH-1:WIDTH]};
    assign w_mcand_ext = {r_sgn & r_mcand[WIDTH-1], r_mcand};
    // For signed operands the multiplier MSB carries negative weight, so the
    // last step subtracts the multiplicand.
    assign w_addend    = r_acc[0] ? ((r_sgn && w_last) ? (-w_mcand_ext) : w_mcand_ext)
                                  : '0;
    assign w_sum       = w_upper_ext + w_addend;
    assign w_acc_next  = {w_sum, r_acc[WIDTH-1:1]};

    assign busy = (r_state == RUN);
    assign done = r_done;
    assign P    = r_p;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: accept a request in IDLE, leave RUN after the final step.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_next = RUN;
            RUN:     if (w_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, shift-add iteration, result load and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_p     <= '0;
            r_done  <= 1'b0;
            r_sgn   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_mcand <= a;
                r_acc   <= {{WIDTH{1'b0}}, b};
                r_cnt   <= '0;
                r_sgn   <= w_sgn_in;
            end else if (r_state == RUN) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_p    <= w_acc_next;
                    r_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_mul_param.sv
// Testbench for serial_mul_param (WIDTH=4): scoreboard of expected products,
// popped whenever done pulses; also checks reset values, latency and P hold.
module tb_serial_mul_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       sgn = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] P;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] prev_p = '0;
    logic       rst_q = 1'b1;

    serial_mul_param #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_MUL_SIGNED_EN
        .sgn   (sgn),
`endif
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [3:0] x, input logic [3:0] y, input logic s);
        logic signed [7:0] sx;
        logic signed [7:0] sy;
        logic signed [7:0] prod;
        if (s) begin
            sx = {{4{x[3]}}, x};
            sy = {{4{y[3]}}, y};
        end else begin
            sx = {4'b0, x};
            sy = {4'b0, y};
        end
        prod = sx * sy;
        return prod;
    endfunction

    // Remember whether reset was applied at the most recent edge.
    always @(posedge clk) rst_q <= rst;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_q) begin
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_P", P, 0);
            prev_p = P;
        end else if (done) begin
            if (exp_q.size() == 0) begin
                check("done_unexpected", done, 0);
            end else begin
                check("P", P, exp_q.pop_front());
            end
            prev_p = P;
        end else begin
            check("P_hold", P, prev_p);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single edge and record the expected product.
    task automatic issue(input logic [3:0] ta, input logic [3:0] tb, input logic ts);
        a = ta;
        b = tb;
        sgn = ts;
        start = 1'b1;
        exp_q.push_back(model(ta, tb, ts));
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    // Wait (bounded) for done, checking how many edges it took.
    task automatic wait_done(input int exp_lat);
        int lat;
        lat = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
            if (!done) check("busy_run", busy, 1);
        end
        check("latency", lat, exp_lat);
        check("busy_at_done", busy, 0);
    endtask

    initial begin
        // Reset for two edges.
        rst = 1'b1;
        tick();
        tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_P", P, 8'h00);
        rst = 1'b0;

        // Max operands; P must stay put afterwards.
        issue(4'd15, 4'd15, 1'b0);
        wait_done(4);
        check("P_15x15", P, 8'hE1);
        tick();
        check("done_one_cycle", done, 0);
        repeat (3) tick();
        check("P_held", P, 8'hE1);

        // Zero multiplicand keeps full latency.
        issue(4'd0, 4'd9, 1'b0);
        wait_done(4);
        check("P_0x9", P, 8'h00);

        // Exhaustive back-to-back sweep: next start issued in the done cycle.
        tick();
        issue(4'd0, 4'd0, 1'b0);
        for (int i = 1; i < 256; i++) begin
            wait_done(4);
            issue(4'(i >> 4), 4'(i), 1'b0);
        end
        wait_done(4);
        tick();

        // Start while busy is ignored.
        issue(4'd5, 4'd6, 1'b0);
        tick();
        a = 4'd3;
        b = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(2);
        check("P_ignore_restart", P, 8'h1E);
        repeat (6) tick();

        // Reset mid-operation discards the result.
        issue(4'd7, 4'd7, 1'b0);
        tick();
        void'(exp_q.pop_back());
        rst = 1'b1;
        tick();
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_P", P, 8'h00);
        rst = 1'b0;
        issue(4'd2, 4'd3, 1'b0);
        wait_done(4);
        check("P_after_abort", P, 8'h06);

`ifdef SERIAL_MUL_SIGNED_EN
        tick();
        issue(4'h8, 4'h7, 1'b1);
        wait_done(4);
        check("P_s_8x7", P, 8'hC8);
        tick();
        issue(4'h8, 4'h8, 1'b1);
        wait_done(4);
        check("P_s_8x8", P, 8'h40);
        tick();
        issue(4'h8, 4'h8, 1'b0);
        wait_done(4);
        check("P_u_8x8", P, 8'h40);
`endif

        repeat (3) tick();
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
